// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencing FSM for a 16-bit subtract-and-compare GCD datapath.
// Drives operand-select muxes, register load enables and subtractor direction
// from the datapath's comparator flags; reports done, error and the number of
// subtractions performed. Carries no operand data.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a computation (sampled in IDLE or ERR only)
//   eq, gt, lt        comparator flags on the registered operands
//   a_zero, b_zero    zero flags on the registered operands
//   sel_in1, sel_in2  A/B register mux select: 0 = data_in, 1 = subtractor
//   sel_sub           subtractor direction: 0 = A-B, 1 = B-A
//   ld_a, ld_b        A/B register load enables
//   sel_out           result mux select (0 = A, 1 = B), registered
//   busy, done, err   in progress / one-cycle result valid / held error
//   iter_cnt          subtractions in the current or last run
module gcd_ctrl #(
  parameter int unsigned            CNT_W    = 16,
  parameter logic [CNT_W-1:0]       MAX_ITER = CNT_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  input  logic             a_zero,
  input  logic             b_zero,
  output logic             sel_in1,
  output logic             sel_in2,
  output logic             sel_sub,
  output logic             ld_a,
  output logic             ld_b,
  output logic             sel_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CHECK,
    SUB_A,
    SUB_B,
    DONE,
    ERR
  } state_e;

  state_e             state_q, state_d;
  logic               sel_out_q, sel_out_d;
  logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0]   iter_inc;

  // Saturating increment so a wide MAX_ITER can never wrap the counter.
  assign iter_inc = (iter_cnt_q == '1) ? iter_cnt_q : iter_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_out_q  <= 1'b0;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_out_q  <= sel_out_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_out_d  = sel_out_q;
    iter_cnt_d = iter_cnt_q;
    sel_in1    = 1'b0;
    sel_in2    = 1'b0;
    sel_sub    = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        ld_a       = 1'b1;
        busy       = 1'b1;
        iter_cnt_d = '0;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        ld_b    = 1'b1;
        busy    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        // Zero operands are decided before equality: gcd(0,x) = x, gcd(0,0) undefined.
        if (a_zero && b_zero) begin
          state_d = ERR;
        end else if (a_zero) begin
          state_d   = DONE;
          sel_out_d = 1'b1;
        end else if (b_zero) begin
          state_d   = DONE;
          sel_out_d = 1'b0;
        end else if (eq) begin
          state_d   = DONE;
          sel_out_d = 1'b0;
        end else if (iter_cnt_q == MAX_ITER) begin
          state_d = ERR;
        end else if (gt) begin
          state_d = SUB_A;
        end else if (lt) begin
          state_d = SUB_B;
        end else begin
          state_d = ERR;
        end
      end
      SUB_A: begin
        ld_a       = 1'b1;
        sel_in1    = 1'b1;
        busy       = 1'b1;
        iter_cnt_d = iter_inc;
        state_d    = CHECK;
      end
      SUB_B: begin
        ld_b       = 1'b1;
        sel_in2    = 1'b1;
        sel_sub    = 1'b1;
        busy       = 1'b1;
        iter_cnt_d = iter_inc;
        state_d    = CHECK;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_d = LOAD_A;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_out  = sel_out_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Testbench for gcd_ctrl: wraps two controllers (default budget and MAX_ITER=3)
// in behavioural 16-bit GCD datapaths and checks directed runs by cycle number.
// Cycle 1 is the cycle after the clock edge that samples start.
module tb_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        start0, start1;

  always #5 clk = ~clk;

  // Instance 0: default MAX_ITER
  logic        eq0, gt0, lt0, az0, bz0;
  logic        s1_0, s2_0, ss0, lda0, ldb0, so0, busy0, done0, err0;
  logic [15:0] it0, a0_q, b0_q, sub0;
  logic [7:0]  ctl0;

  assign sub0 = ss0 ? (b0_q - a0_q) : (a0_q - b0_q);
  always @(posedge clk) begin
    if (lda0) a0_q <= s1_0 ? sub0 : data_in;
    if (ldb0) b0_q <= s2_0 ? sub0 : data_in;
  end
  assign eq0  = (a0_q == b0_q);
  assign gt0  = (a0_q > b0_q);
  assign lt0  = (a0_q < b0_q);
  assign az0  = (a0_q == 16'd0);
  assign bz0  = (b0_q == 16'd0);
  assign ctl0 = {lda0, ldb0, s1_0, s2_0, ss0, busy0, done0, err0};

  gcd_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start0),
    .eq(eq0), .gt(gt0), .lt(lt0), .a_zero(az0), .b_zero(bz0),
    .sel_in1(s1_0), .sel_in2(s2_0), .sel_sub(ss0), .ld_a(lda0), .ld_b(ldb0),
    .sel_out(so0), .busy(busy0), .done(done0), .err(err0), .iter_cnt(it0)
  );

  // Instance 1: MAX_ITER = 3
  logic        eq1, gt1, lt1, az1, bz1;
  logic        s1_1, s2_1, ss1, lda1, ldb1, so1, busy1, done1, err1;
  logic [15:0] it1, a1_q, b1_q, sub1;
  logic [7:0]  ctl1;

  assign sub1 = ss1 ? (b1_q - a1_q) : (a1_q - b1_q);
  always @(posedge clk) begin
    if (lda1) a1_q <= s1_1 ? sub1 : data_in;
    if (ldb1) b1_q <= s2_1 ? sub1 : data_in;
  end
  assign eq1  = (a1_q == b1_q);
  assign gt1  = (a1_q > b1_q);
  assign lt1  = (a1_q < b1_q);
  assign az1  = (a1_q == 16'd0);
  assign bz1  = (b1_q == 16'd0);
  assign ctl1 = {lda1, ldb1, s1_1, s2_1, ss1, busy1, done1, err1};

  gcd_ctrl #(.CNT_W(16), .MAX_ITER(16'd3)) u_dut_max (
    .clk(clk), .rst(rst), .start(start1),
    .eq(eq1), .gt(gt1), .lt(lt1), .a_zero(az1), .b_zero(bz1),
    .sel_in1(s1_1), .sel_in2(s2_1), .sel_sub(ss1), .ld_a(lda1), .ld_b(ldb1),
    .sel_out(so1), .busy(busy1), .done(done1), .err(err1), .iter_cnt(it1)
  );

  // ctl bit order: {ld_a, ld_b, sel_in1, sel_in2, sel_sub, busy, done, err}
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_LDA   = 8'b1000_0100;
  localparam logic [7:0] C_LDB   = 8'b0100_0100;
  localparam logic [7:0] C_CHK   = 8'b0000_0100;
  localparam logic [7:0] C_SUBA  = 8'b1010_0100;
  localparam logic [7:0] C_SUBB  = 8'b0101_1100;
  localparam logic [7:0] C_DONE  = 8'b0000_0010;
  localparam logic [7:0] C_ERR   = 8'b0000_0001;

  logic [7:0]  tr_ctl [0:31];
  logic [15:0] tr_it  [0:31];
  logic        tr_so  [0:31];
  logic [15:0] tr_res [0:31];

  int checks = 0;
  int errors = 0;

  // Starts a run on the selected instance and records outputs in cycles 1..ncyc.
  // poke raises start on instance 0 in cycles 5 and 6 (mid-computation).
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int ncyc,
                     input bit inst, input bit poke);
    @(negedge clk);
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      tr_ctl[c] = inst ? ctl1 : ctl0;
      tr_it[c]  = inst ? it1 : it0;
      tr_so[c]  = inst ? so1 : so0;
      tr_res[c] = inst ? (so1 ? b1_q : a1_q) : (so0 ? b0_q : a0_q);
      start0 = 1'b0;
      start1 = 1'b0;
      if (poke && (c == 5 || c == 6)) start0 = 1'b1;
      data_in = (c == 1) ? a : b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data_in = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ctl0 !== C_IDLE) begin errors++; $display("FAIL reset_ctl0: got %b expected %b", ctl0, C_IDLE); end
    checks++; if (ctl1 !== C_IDLE) begin errors++; $display("FAIL reset_ctl1: got %b expected %b", ctl1, C_IDLE); end
    checks++; if (it0 !== 16'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", it0); end
    checks++; if (so0 !== 1'b0) begin errors++; $display("FAIL reset_sel_out: got %b expected 0", so0); end
    rst = 1'b0;
  endtask

  task automatic test_12_8();
    logic [7:0] exp_ctl [1:9];
    exp_ctl = '{C_LDA, C_LDB, C_CHK, C_SUBA, C_CHK, C_SUBB, C_CHK, C_DONE, C_IDLE};
    run(16'd12, 16'd8, 9, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (tr_ctl[c] !== exp_ctl[c]) begin
        errors++; $display("FAIL g12_8_ctl cycle %0d: got %b expected %b", c, tr_ctl[c], exp_ctl[c]);
      end
    end
    checks++; if (tr_it[8] !== 16'd2) begin errors++; $display("FAIL g12_8_iter: got %0d expected 2", tr_it[8]); end
    checks++; if (tr_so[8] !== 1'b0) begin errors++; $display("FAIL g12_8_sel_out: got %b expected 0", tr_so[8]); end
    checks++; if (tr_res[8] !== 16'd4) begin errors++; $display("FAIL g12_8_result: got %0d expected 4", tr_res[8]); end
  endtask

  task automatic test_48_18_busy_start();
    logic busy_ok;
    run(16'd48, 16'd18, 16, 1'b0, 1'b1);
    busy_ok = 1'b1;
    for (int c = 1; c <= 11; c++) if (tr_ctl[c][2] !== 1'b1) busy_ok = 1'b0;
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL g48_18_busy_1_11: got %b expected 1", busy_ok); end
    checks++; if (tr_ctl[12] !== C_DONE) begin errors++; $display("FAIL g48_18_done12: got %b expected %b", tr_ctl[12], C_DONE); end
    checks++; if (tr_ctl[11] !== C_CHK) begin errors++; $display("FAIL g48_18_chk11: got %b expected %b", tr_ctl[11], C_CHK); end
    checks++; if (tr_it[12] !== 16'd4) begin errors++; $display("FAIL g48_18_iter: got %0d expected 4", tr_it[12]); end
    checks++; if (tr_res[12] !== 16'd6) begin errors++; $display("FAIL g48_18_result: got %0d expected 6", tr_res[12]); end
    // no restart from the mid-run start pulses; counter held afterwards
    checks++; if (tr_ctl[16] !== C_IDLE) begin errors++; $display("FAIL g48_18_idle_after: got %b expected %b", tr_ctl[16], C_IDLE); end
    checks++; if (tr_it[16] !== 16'd4) begin errors++; $display("FAIL g48_18_iter_hold: got %0d expected 4", tr_it[16]); end
  endtask

  task automatic test_back_to_back();
    run(16'd12, 16'd8, 8, 1'b0, 1'b0);
    checks++; if (tr_ctl[8] !== C_DONE) begin errors++; $display("FAIL b2b_first_done: got %b expected %b", tr_ctl[8], C_DONE); end
    // start raised in the IDLE cycle right after DONE
    run(16'd0, 16'd21, 5, 1'b0, 1'b0);
    checks++; if (tr_ctl[1] !== C_LDA) begin errors++; $display("FAIL b2b_load_a: got %b expected %b", tr_ctl[1], C_LDA); end
    checks++; if (tr_ctl[4] !== C_DONE) begin errors++; $display("FAIL zero_a_done4: got %b expected %b", tr_ctl[4], C_DONE); end
    checks++; if (tr_so[4] !== 1'b1) begin errors++; $display("FAIL zero_a_sel_out: got %b expected 1", tr_so[4]); end
    checks++; if (tr_res[4] !== 16'd21) begin errors++; $display("FAIL zero_a_result: got %0d expected 21", tr_res[4]); end
    checks++; if (tr_it[4] !== 16'd0) begin errors++; $display("FAIL zero_a_iter: got %0d expected 0", tr_it[4]); end
  endtask

  task automatic test_rst_mid();
    run(16'd48, 16'd18, 5, 1'b0, 1'b0);
    @(negedge clk); // cycle 6: second SUB_A (30-18)
    checks++; if (ctl0 !== C_SUBA) begin errors++; $display("FAIL rst_pre_state: got %b expected %b", ctl0, C_SUBA); end
    checks++; if (it0 !== 16'd1) begin errors++; $display("FAIL rst_pre_iter: got %0d expected 1", it0); end
    rst = 1'b1;
    #1;
    checks++; if (ctl0 !== C_IDLE) begin errors++; $display("FAIL rst_mid_ctl: got %b expected %b", ctl0, C_IDLE); end
    checks++; if (it0 !== 16'd0) begin errors++; $display("FAIL rst_mid_iter: got %0d expected 0", it0); end
    checks++; if (so0 !== 1'b0) begin errors++; $display("FAIL rst_mid_sel_out: got %b expected 0", so0); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ctl0 !== C_IDLE) begin errors++; $display("FAIL rst_stays_idle: got %b expected %b", ctl0, C_IDLE); end
  endtask

  task automatic test_err_restart();
    logic err_held;
    run(16'd0, 16'd0, 8, 1'b0, 1'b0);
    checks++; if (tr_ctl[3] !== C_CHK) begin errors++; $display("FAIL err_chk3: got %b expected %b", tr_ctl[3], C_CHK); end
    err_held = 1'b1;
    for (int c = 4; c <= 8; c++) if (tr_ctl[c] !== C_ERR) err_held = 1'b0;
    checks++; if (err_held !== 1'b1) begin errors++; $display("FAIL err_held_4_8: got %b expected 1", err_held); end
    run(16'd9, 16'd9, 5, 1'b0, 1'b0);
    checks++; if (tr_ctl[1] !== C_LDA) begin errors++; $display("FAIL err_restart_load_a: got %b expected %b", tr_ctl[1], C_LDA); end
    checks++; if (tr_ctl[4] !== C_DONE) begin errors++; $display("FAIL err_restart_done4: got %b expected %b", tr_ctl[4], C_DONE); end
    checks++; if (tr_res[4] !== 16'd9) begin errors++; $display("FAIL err_restart_result: got %0d expected 9", tr_res[4]); end
  endtask

  task automatic test_max_iter();
    logic saw_done;
    run(16'd48, 16'd18, 12, 1'b1, 1'b0);
    saw_done = 1'b0;
    for (int c = 1; c <= 12; c++) if (tr_ctl[c][1] !== 1'b0) saw_done = 1'b1;
    checks++; if (tr_ctl[9] !== C_CHK) begin errors++; $display("FAIL max_chk9: got %b expected %b", tr_ctl[9], C_CHK); end
    checks++; if (tr_ctl[10] !== C_ERR) begin errors++; $display("FAIL max_err10: got %b expected %b", tr_ctl[10], C_ERR); end
    checks++; if (tr_ctl[12] !== C_ERR) begin errors++; $display("FAIL max_err_held: got %b expected %b", tr_ctl[12], C_ERR); end
    checks++; if (tr_it[10] !== 16'd3) begin errors++; $display("FAIL max_iter_cnt: got %0d expected 3", tr_it[10]); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL max_no_done: got %b expected 0", saw_done); end
  endtask

  initial begin
    test_reset();
    test_12_8();
    test_48_18_busy_start();
    test_back_to_back();
    test_rst_mid();
    test_err_restart();
    test_max_iter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Sequencing FSM for the 16-bit subtract-and-compare GCD datapath: it drives the 2:1 operand-select muxes, register load enables and subtractor direction, using the comparator flags returned by the datapath. It accepts a start pulse, sequences operand loading and repeated subtraction until A == B or a zero operand is found, then reports done, error and iteration count. Pure control: it carries no operand data.

## Interface
- CNT_W, 16: width of the iteration counter.
- MAX_ITER, 16'hFFFF: subtraction budget; reaching it without termination is an error.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a computation; sampled only in IDLE or ERR
- eq / gt / lt  in  1 each  datapath comparator flags (A==B, A>B, A<B) from the registered operands
- a_zero / b_zero  in  1 each  A==0 / B==0 flags from the datapath
- sel_in1  out  1  A-register mux select: 0 = external data_in, 1 = subtractor output
- sel_in2  out  1  B-register mux select, same encoding
- sel_sub  out  1  subtractor direction: 0 = A-B, 1 = B-A
- ld_a / ld_b  out  1 each  load enables for the A / B registers
- sel_out  out  1  result mux: 0 = A, 1 = B; registered
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse, result valid
- err  out  1  error, held
- iter_cnt  out  CNT_W  subtractions performed in the current or last run

## Operation
- States: IDLE, LOAD_A, LOAD_B, CHECK, SUB_A, SUB_B, DONE, ERR. The state register is the only state besides sel_out and iter_cnt.
- Outputs other than sel_out and iter_cnt are Moore-decoded from the state. Any output not listed for a state is 0.
- IDLE: start=1 -> LOAD_A.
- LOAD_A: ld_a=1, sel_in1=0, busy=1. iter_cnt cleared. Always -> LOAD_B.
- LOAD_B: ld_b=1, sel_in2=0, busy=1. Always -> CHECK.
- CHECK: busy=1. Decisions in priority order:
  - a_zero & b_zero -> ERR.
  - a_zero -> DONE, with sel_out<=1.
  - b_zero -> DONE, with sel_out<=0.
  - eq -> DONE, with sel_out<=0.
  - iter_cnt == MAX_ITER -> ERR.
  - gt -> SUB_A.
  - lt -> SUB_B.
  - no flag set -> ERR.
- SUB_A: ld_a=1, sel_in1=1, sel_sub=0, busy=1. iter_cnt+1 (saturating). -> CHECK.
- SUB_B: ld_b=1, sel_in2=1, sel_sub=1, busy=1. iter_cnt+1 (saturating). -> CHECK.
- DONE: done=1 for exactly one cycle, then -> IDLE. start is ignored in DONE.
- ERR: err=1, held.
  - start=1 -> LOAD_A; err drops on that transition.
  - start=0 -> stay in ERR.
- start is ignored while busy. There is no abort input; only rst aborts.
- sel_out and iter_cnt hold their values after DONE/ERR until the next LOAD_A.

## Timing
- Reset (async, any state, including mid-computation): state=IDLE, iter_cnt=0, sel_out=0. All outputs are 0.
- Upstream protocol:
  - start is sampled at edge 0.
  - data_in must carry A during cycle 1 (LOAD_A) and B during cycle 2 (LOAD_B).
- The first CHECK is cycle 3. Comparator flags must be valid combinationally in every CHECK cycle.
- Each subtraction costs 2 cycles (SUB, then CHECK). For N subtractions:
  - done is asserted in cycle 4+2N.
  - busy is high for cycles 1 through 3+2N.
- MAX_ITER error: err rises in cycle 4+2·MAX_ITER, with iter_cnt = MAX_ITER.
- Restart: start in ERR at edge k puts the block in LOAD_A in cycle k+1.
- Restart after DONE: the earliest accepted start is in the IDLE cycle following DONE.

## Test plan
The bench instantiates a behavioural 16-bit datapath (two 2:1 muxes, A/B registers, subtractor, comparator) around the controller.
- A=12, B=8, start at cycle 0 -> subtractions are A:=4, then B:=4. done pulses in cycle 8; sel_out=0; iter_cnt=2; result 4.
- A=48, B=18 -> done in cycle 12; iter_cnt=4; result 6. busy=1 in cycles 1–11 and 0 in cycle 12.
- A=0, B=21 -> done in cycle 4; sel_out=1; result 21; iter_cnt=0.
- A=0, B=0 -> err=1 from cycle 4 and held. A later start with A=9, B=9 -> err clears, done in cycle 4 of the new run, result 9.
- MAX_ITER=3, A=48, B=18 -> err=1 in cycle 10; iter_cnt=3; done never asserted.
- rst pulsed during SUB_A of the 48/18 run -> all outputs 0 immediately, state IDLE. start pulses while busy in any run are ignored: no restart, and iter_cnt is unaffected.
